// File: rtl/fp_pkg.sv
// Shared floating-point constants and FSM encoding for the adder back end.
package fp_pkg;

    localparam int          EXP_W      = 8;
    localparam int          FRAC_W     = 23;
    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam int          BIAS       = 127;
    localparam int          MANT_W     = FRAC_W + 4;
    localparam int          XEXP_W     = EXP_W + 2;
    localparam logic [4:0]  MAX_SHIFTS = 5'd24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a hidden+fraction significand.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [FRAC_W:0] mant_i,
    input  logic            guard_i,
    input  logic            sticky_i,
    output logic [FRAC_W:0] mant_o,
    output logic            carry_o
);

    logic              inc_s;
    logic [FRAC_W+1:0] sum_s;

    // Ties go to the even significand.
    always_comb begin
        inc_s   = guard_i & (sticky_i | mant_i[0]);
        sum_s   = {1'b0, mant_i} + {{(FRAC_W + 1){1'b0}}, inc_s};
        mant_o  = sum_s[FRAC_W:0];
        carry_o = sum_s[FRAC_W+1];
    end

endmodule

// File: rtl/fp_add_normalizer.sv
// Normalises, rounds and packs a raw adder result into IEEE-754 single format.
module fp_add_normalizer
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [MANT_W-1:0]    in_mant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          result,
    output logic                 busy
);

    fsm_state_e          state_q, state_d;
    logic                sign_q, sign_d;
    logic [XEXP_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [4:0]          shift_cnt_q, shift_cnt_d;
    logic                zero_q, zero_d;
    logic                special_q, special_d;
    logic [31:0]         result_q, result_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic [FRAC_W:0]     rnd_mant_s;
    logic                rnd_carry_s;
    logic [FRAC_W:0]     fin_mant_s;
    logic [XEXP_W-1:0]   fin_exp_s;
    logic [31:0]         packed_s;

    fp_round_rne u_round (
        .mant_i   (mant_q[MANT_W-2:2]),
        .guard_i  (mant_q[1]),
        .sticky_i (mant_q[0]),
        .mant_o   (rnd_mant_s),
        .carry_o  (rnd_carry_s)
    );

    // Post-rounding renormalisation and final IEEE packing.
    always_comb begin
        if (rnd_carry_s) begin
            fin_mant_s = {1'b1, rnd_mant_s[FRAC_W:1]};
            fin_exp_s  = exp_q + 10'd1;
        end else begin
            fin_mant_s = rnd_mant_s;
            fin_exp_s  = exp_q;
        end

        if (zero_q) begin
            packed_s = 32'h0000_0000;
        end else if (fin_exp_s >= 10'd255) begin
            packed_s = {sign_q, EXP_MAX, 23'h0};
        end else if (fin_mant_s[FRAC_W]) begin
            packed_s = {sign_q, fin_exp_s[EXP_W-1:0], fin_mant_s[FRAC_W-1:0]};
        end else begin
            packed_s = {sign_q, 8'h00, fin_mant_s[FRAC_W-1:0]};
        end
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        shift_cnt_d = shift_cnt_q;
        zero_d      = zero_q;
        special_d   = special_q;
        result_d    = result_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d      = in_sign;
                    special_d   = (in_exp == EXP_MAX);
                    zero_d      = (in_mant == {MANT_W{1'b0}});
                    shift_cnt_d = 5'd0;
                    // Adder carry: fold the dropped bit into sticky.
                    if (in_mant[MANT_W-1] && (in_exp != EXP_MAX)) begin
                        mant_d = {1'b0, in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
                        exp_d  = {2'b00, in_exp} + 10'd1;
                    end else begin
                        mant_d = in_mant;
                        exp_d  = {2'b00, in_exp};
                    end
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (special_q) begin
                    result_d = {sign_q, EXP_MAX, mant_q[FRAC_W+1:2]};
                    state_d  = ST_DONE;
                end else if (!mant_q[MANT_W-2] && (mant_q != {MANT_W{1'b0}}) &&
                             (exp_q > 10'd1) && (shift_cnt_q < MAX_SHIFTS)) begin
                    mant_d      = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d       = exp_q - 10'd1;
                    shift_cnt_d = shift_cnt_q + 5'd1;
                    state_d     = ST_NORM;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                result_d = packed_s;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= 10'd0;
            mant_q      <= 27'd0;
            shift_cnt_q <= 5'd0;
            zero_q      <= 1'b0;
            special_q   <= 1'b0;
            result_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            shift_cnt_q <= shift_cnt_d;
            zero_q      <= zero_d;
            special_q   <= special_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule
